// File: rtl/dbus_agent_pkg.sv
// Shared types and helpers for the data-bus agent: access sizes, FSM states,
// dbus request/response structs and lane-mask helpers.
package dbus_agent_pkg;

    localparam int DBUS_ADDR_W = 64;
    localparam int DBUS_DATA_W = 64;

    typedef logic [7:0] u8;

    typedef enum logic [1:0] {
        MSIZE_B = 2'd0,
        MSIZE_H = 2'd1,
        MSIZE_W = 2'd2,
        MSIZE_D = 2'd3
    } msize_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2,
        DONE = 2'd3
    } dbus_state_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    // Byte-lane mask of an access of the given size, before lane shifting.
    function automatic u8 size_mask(msize_t s);
        case (s)
            MSIZE_B: return 8'h01;
            MSIZE_H: return 8'h03;
            MSIZE_W: return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(msize_t s);
        case (s)
            MSIZE_B: return 3'b000;
            MSIZE_H: return 3'b001;
            MSIZE_W: return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/dbus_agent_if.sv
// Core-side data bus: request driven by the agent (master), response
// returned by the memory system (slave).
interface dbus_agent_if;
    import dbus_agent_pkg::*;

    dbus_req_t  dreq;
    dbus_resp_t dresp;

    modport master (output dreq, input dresp);
    modport slave  (input dreq, output dresp);

endinterface

// File: rtl/dbus_agent_align.sv
// dbus_align: combinational byte-lane steering. Store side shifts data and
// strobe into the addressed lanes; load side shifts the bus word down and
// sign- or zero-extends it to 64 bits.
module dbus_align
    import dbus_agent_pkg::*;
(
    input  msize_t      st_size_i,
    input  logic [2:0]  st_off_i,
    input  logic [63:0] wdata_i,
    output logic [7:0]  st_strobe_o,
    output logic [63:0] st_data_o,
    input  msize_t      ld_size_i,
    input  logic [2:0]  ld_off_i,
    input  logic        ld_unsigned_i,
    input  logic [63:0] bus_rdata_i,
    output logic [63:0] ld_data_o
);

    logic [63:0] raw;

    assign st_strobe_o = size_mask(st_size_i) << st_off_i;
    assign st_data_o   = wdata_i << {st_off_i, 3'b000};
    assign raw         = bus_rdata_i >> {ld_off_i, 3'b000};

    // Truncate the shifted bus word to the access size and extend it.
    always_comb begin
        ld_data_o = raw;
        case (ld_size_i)
            MSIZE_B: ld_data_o = ld_unsigned_i ? {56'h0, raw[7:0]}
                                               : {{56{raw[7]}}, raw[7:0]};
            MSIZE_H: ld_data_o = ld_unsigned_i ? {48'h0, raw[15:0]}
                                               : {{48{raw[15]}}, raw[15:0]};
            MSIZE_W: ld_data_o = ld_unsigned_i ? {32'h0, raw[31:0]}
                                               : {{32{raw[31]}}, raw[31:0]};
            default: ld_data_o = raw;
        endcase
    end

endmodule

// File: rtl/dbus_agent.sv
// dbus_agent: memory-stage load/store unit. Issues one dbus transaction per
// memory instruction, holds the request stable until data_ok, stalls the
// pipeline meanwhile and drains an in-flight transaction after a flush.
// Optional feature macro: DBUS_ALIGN_CHECK_EN (reject misaligned accesses);
// when undefined, addresses are aligned down to the access size.
module dbus_agent
    import dbus_agent_pkg::*;
#(
    parameter int ADDR_W = DBUS_ADDR_W,
    parameter int DATA_W = DBUS_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              acc_valid,
    input  logic              acc_store,
    input  logic [1:0]        acc_size,
    input  logic              acc_unsigned,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [DATA_W-1:0] acc_wdata,
    input  logic              advance,
    input  logic              flush,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              misaligned,
    dbus_agent_if.master      dbus
);

    dbus_state_t       state_q, state_d;
    dbus_req_t         req_q;
    logic              store_q;
    logic              uns_q;
    logic [DATA_W-1:0] rdata_q;
    logic              mis_q;

    msize_t            acc_sz;
    logic [2:0]        low_mask;
    logic              acc_mis;
    logic [ADDR_W-1:0] acc_addr_eff;
    logic              accept;
    logic              data_ok;
    logic [7:0]        st_strobe;
    logic [63:0]       st_data;
    logic [63:0]       ld_data;
    logic              unused_addr_ok;

    assign acc_sz         = msize_t'(acc_size);
    assign low_mask       = align_mask(acc_sz);
    assign data_ok        = dbus.dresp.data_ok;
    assign unused_addr_ok = dbus.dresp.addr_ok;
    assign accept         = (state_q == IDLE) && acc_valid && !flush;

`ifdef DBUS_ALIGN_CHECK_EN
    assign acc_mis      = |(acc_addr[2:0] & low_mask);
    assign acc_addr_eff = acc_addr;
`else
    assign acc_mis      = 1'b0;
    assign acc_addr_eff = {acc_addr[ADDR_W-1:3], acc_addr[2:0] & ~low_mask};
`endif

    dbus_align u_align (
        .st_size_i     (acc_sz),
        .st_off_i      (acc_addr_eff[2:0]),
        .wdata_i       (acc_wdata),
        .st_strobe_o   (st_strobe),
        .st_data_o     (st_data),
        .ld_size_i     (req_q.size),
        .ld_off_i      (req_q.addr[2:0]),
        .ld_unsigned_i (uns_q),
        .bus_rdata_i   (dbus.dresp.data),
        .ld_data_o     (ld_data)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; data_ok wins over flush so a response is never lost.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = acc_mis ? DONE : REQ;
            REQ: begin
                if (data_ok)    state_d = flush ? IDLE : DONE;
                else if (flush) state_d = DROP;
            end
            DROP: if (data_ok) state_d = IDLE;
            DONE: if (advance || flush) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: request is visible only while a transaction is outstanding.
    always_comb begin
        stall     = 1'b0;
        dbus.dreq = '0;
        case (state_q)
            IDLE: stall = acc_valid && !flush;
            REQ: begin
                stall     = 1'b1;
                dbus.dreq = req_q;
            end
            DROP: begin
                stall     = acc_valid;
                dbus.dreq = req_q;
            end
            default: stall = 1'b0;
        endcase
    end

    // Capture the aligned request when an access is accepted; held until the next accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_q <= '{valid:  1'b1,
                       addr:   acc_addr_eff,
                       size:   acc_sz,
                       strobe: acc_store ? st_strobe : 8'h00,
                       data:   acc_store ? st_data : 64'h0};
            store_q <= acc_store;
            uns_q   <= acc_unsigned;
        end
    end

    // Result registers: load data or misalignment flag, held through DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else if (accept && acc_mis) begin
            rdata_q <= '0;
            mis_q   <= 1'b1;
        end else if ((state_q == REQ) && data_ok && !flush) begin
            rdata_q <= store_q ? '0 : ld_data;
            mis_q   <= 1'b0;
        end else if ((state_q == DONE) && (advance || flush)) begin
            mis_q   <= 1'b0;
        end
    end

    assign rdata      = rdata_q;
    assign misaligned = mis_q;

endmodule
